// File: rtl/spi_hex_display_ctrl_if.sv
// SPI link and received-word signals between the Arduino-side master and the
// hex display controller. Display pins stay on the controller itself.
interface spi_hex_display_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              arduino_sclk;
   logic              arduino_mosi;
   logic              arduino_ss_n;
   logic              fpga_physical_miso;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              frame_error;

   // Handshake: data_valid and frame_error are single-cycle qualifiers with no
   // ready; the consumer samples data_out on the cycle data_valid is high (it
   // then holds until the next good frame). The slave cannot apply back-pressure.
   modport master (
      output arduino_sclk, arduino_mosi, arduino_ss_n,
      input  fpga_physical_miso, data_out, data_valid, frame_error
   );

   modport slave (
      input  arduino_sclk, arduino_mosi, arduino_ss_n,
      output fpga_physical_miso, data_out, data_valid, frame_error
   );
endinterface

// File: rtl/spi_hex_display_ctrl.sv
// SPI mode-0 slave that keeps the last correctly framed DATA_W-bit word,
// echoes it on MISO during the next frame, and shows it as DATA_W/4 hex digits
// on a time-multiplexed seven-segment display.
module spi_hex_display_ctrl #(
   parameter int DATA_W         = 8,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  FPGA_clk,
   input  logic                  FPGA_reset,
   spi_hex_display_ctrl_if.slave spi,
   output logic [6:0]            seven_segment_pins,
   output logic [DATA_W/4-1:0]   digit_enable,
   output logic [1:0]            dbg_state_o
);
   localparam int N_DIG = DATA_W / 4;
   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam int REF_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

   // Reset view of the display: a "0" on digit 0, after polarity.
   localparam logic [6:0]       SEG_ZERO = 7'h3F;
   localparam logic [6:0]       SEG_RST  = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
   localparam logic [N_DIG-1:0] EN_ONE   = N_DIG'(1);
   localparam logic [N_DIG-1:0] EN_RST   = SEG_ACTIVE_LOW ? ~EN_ONE : EN_ONE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } frame_state_t;

   // ---------------------------------------------------------------------
   // Input synchronisers (bit 1 is the synchronised value, bit 2 the
   // previous one for edge detection)
   // ---------------------------------------------------------------------
   logic [2:0] sclk_q;
   logic [1:0] mosi_q;
   logic [2:0] ss_q;

   // Bring the asynchronous SPI pins into the FPGA_clk domain.
   always_ff @(posedge FPGA_clk) begin
      if (FPGA_reset) begin
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
         ss_q   <= 3'b111;
      end else begin
         sclk_q <= {sclk_q[1:0], spi.arduino_sclk};
         mosi_q <= {mosi_q[0], spi.arduino_mosi};
         ss_q   <= {ss_q[1:0], spi.arduino_ss_n};
      end
   end

   logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_low, mosi_s;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];
   assign ss_low    = ~ss_q[1];
   assign mosi_s    = mosi_q[1];

   // ---------------------------------------------------------------------
   // Frame engine
   // ---------------------------------------------------------------------
   frame_state_t      state_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              error_q;

   // Frame FSM: capture bits while selected, judge the length one cycle after
   // the deselect edge so the result pulses land three cycles after the pin.
   always_ff @(posedge FPGA_clk) begin
      if (FPGA_reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ss_fall) begin
                  bit_cnt_q <= '0;
                  rx_q      <= '0;
                  tx_q      <= data_q;
                  state_q   <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (ss_rise) begin
                  state_q <= ST_DONE;
               end else if (ss_low) begin
                  if (sclk_rise) begin
                     rx_q <= {rx_q[DATA_W-2:0], mosi_s};
                     if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end
                  if (sclk_fall) begin
                     tx_q <= {tx_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
            ST_DONE: begin
               if (bit_cnt_q == CNT_FULL) begin
                  data_q  <= rx_q;
                  valid_q <= 1'b1;
               end else begin
                  error_q <= 1'b1;
               end
               // A back-to-back frame echoes the word held before this one.
               if (ss_fall) begin
                  bit_cnt_q <= '0;
                  rx_q      <= '0;
                  tx_q      <= data_q;
                  state_q   <= ST_RECV;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi.fpga_physical_miso = ss_low & tx_q[DATA_W-1];
   assign spi.data_out           = data_q;
   assign spi.data_valid         = valid_q;
   assign spi.frame_error        = error_q;
   assign dbg_state_o            = state_q;

   // ---------------------------------------------------------------------
   // Display multiplexing
   // ---------------------------------------------------------------------
   logic [REF_W-1:0] ref_cnt_q;
   logic [IDX_W-1:0] dig_idx_q;

   // Dwell REFRESH_DIV cycles on each digit, then step to the next one.
   always_ff @(posedge FPGA_clk) begin
      if (FPGA_reset) begin
         ref_cnt_q <= '0;
         dig_idx_q <= '0;
      end else if (ref_cnt_q == REF_LAST) begin
         ref_cnt_q <= '0;
         if (N_DIG == 1 || dig_idx_q == IDX_LAST) begin
            dig_idx_q <= '0;
         end else begin
            dig_idx_q <= dig_idx_q + 1'b1;
         end
      end else begin
         ref_cnt_q <= ref_cnt_q + 1'b1;
      end
   end

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [3:0]       nib_d;
   logic [6:0]       seg_d;
   logic [N_DIG-1:0] en_d;

   // Select the current digit's nibble and build its pattern and enable.
   always_comb begin
      nib_d = data_q[{dig_idx_q, 2'b00} +: 4];
      seg_d = hex_to_seg(nib_d);
      en_d  = EN_ONE << dig_idx_q;
      if (SEG_ACTIVE_LOW) begin
         seg_d = ~seg_d;
         en_d  = ~en_d;
      end
   end

   logic [6:0]       seg_q;
   logic [N_DIG-1:0] en_q;

   // Register segments and enable together so they always switch on one edge.
   always_ff @(posedge FPGA_clk) begin
      if (FPGA_reset) begin
         seg_q <= SEG_RST;
         en_q  <= EN_RST;
      end else begin
         seg_q <= seg_d;
         en_q  <= en_d;
      end
   end

   assign seven_segment_pins = seg_q;
   assign digit_enable       = en_q;
endmodule

// File: tb/tb_spi_hex_display_ctrl.sv
// Bench for spi_hex_display_ctrl: an 8-bit active-low instance and a 16-bit
// active-high instance share FPGA clock, reset, SCLK and MOSI; each has its
// own slave select, so traffic to one also exercises "ignore SCLK while
// deselected" on the other.
module tb_spi_hex_display_ctrl;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic [1:0] ss_n = 2'b11;

  always #5 clk = ~clk;

  spi_hex_display_ctrl_if #(.DATA_W(8))  bus8 ();
  spi_hex_display_ctrl_if #(.DATA_W(16)) bus16 ();

  assign bus8.arduino_sclk  = sclk;
  assign bus8.arduino_mosi  = mosi;
  assign bus8.arduino_ss_n  = ss_n[0];
  assign bus16.arduino_sclk = sclk;
  assign bus16.arduino_mosi = mosi;
  assign bus16.arduino_ss_n = ss_n[1];

  logic [6:0] seg8, seg16;
  logic [1:0] en8;
  logic [3:0] en16;
  logic [1:0] dbg8, dbg16;

  spi_hex_display_ctrl #(.DATA_W(8), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut8 (
    .FPGA_clk(clk), .FPGA_reset(rst), .spi(bus8.slave),
    .seven_segment_pins(seg8), .digit_enable(en8), .dbg_state_o(dbg8));

  spi_hex_display_ctrl #(.DATA_W(16), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut16 (
    .FPGA_clk(clk), .FPGA_reset(rst), .spi(bus16.slave),
    .seven_segment_pins(seg16), .digit_enable(en16), .dbg_state_o(dbg16));

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [15:0] model_data [2];   // last good word per instance
  logic [15:0] exp_q[$];         // words expected at the next good-frame check
  int w_of [2] = '{8, 16};
  int ndig_of [2] = '{2, 4};

  // Segment sets by letter, from the usual hex digit shapes.
  string pats [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  typedef struct {
    int          which;
    int          nbits;
    logic [31:0] value;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] r;
    string p;
    r = '0;
    p = pats[nib];
    for (int i = 0; i < p.len(); i++) r[int'(p[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] dout_of(input int which);
    return (which == 0) ? {8'h00, bus8.data_out} : bus16.data_out;
  endfunction
  function automatic logic valid_of(input int which);
    return (which == 0) ? bus8.data_valid : bus16.data_valid;
  endfunction
  function automatic logic err_of(input int which);
    return (which == 0) ? bus8.frame_error : bus16.frame_error;
  endfunction
  function automatic logic miso_of(input int which);
    return (which == 0) ? bus8.fpga_physical_miso : bus16.fpga_physical_miso;
  endfunction
  // Active-high views of the display pins.
  function automatic logic [6:0] seg_h(input int which);
    return (which == 0) ? ~seg8 : seg16;
  endfunction
  function automatic logic [3:0] en_h(input int which);
    return (which == 0) ? {2'b00, ~en8} : en16;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    ss_n = 2'b11;
    wait_cyc(4);
    rst = 1'b0;
    model_data[0] = '0;
    model_data[1] = '0;
  endtask

  // Clocks nbits of value out MSB first; records MISO just before each rise.
  task automatic shift_bits(input int which, input int nbits, input logic [31:0] value,
                            output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = value[nbits-1-i];
      wait_cyc($urandom_range(5, 8));
      cap = {cap[30:0], miso_of(which)};
      sclk = 1'b1;
      wait_cyc($urandom_range(5, 8));
      sclk = 1'b0;
    end
  endtask

  // Whole frame plus result checks against the expected word.
  task automatic do_frame(input int which, input int nbits, input logic [31:0] value,
                          input logic exp_valid, input logic [15:0] exp_data);
    logic [31:0] cap, miso_exp;
    logic [5:0]  v_vec, e_vec, pulse;
    logic [15:0] prev, dout_k2, want;
    int w;
    w = w_of[which];
    prev = model_data[which];
    exp_q.push_back(exp_data);
    @(negedge clk);
    ss_n[which] = 1'b0;
    wait_cyc(6);
    shift_bits(which, nbits, value, cap);
    wait_cyc(6);
    ss_n[which] = 1'b1;
    v_vec = '0;
    e_vec = '0;
    dout_k2 = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      v_vec[k] = valid_of(which);
      e_vec[k] = err_of(which);
      if (k == 2) dout_k2 = dout_of(which);
    end
    pulse = 6'b001000;
    chk($sformatf("valid_timing[%0d]", which), 32'(v_vec), exp_valid ? 32'(pulse) : 32'h0);
    chk($sformatf("error_timing[%0d]", which), 32'(e_vec), exp_valid ? 32'h0 : 32'(pulse));
    chk($sformatf("dout_before_pulse[%0d]", which), 32'(dout_k2), 32'(prev));
    want = exp_q.pop_front();
    chk($sformatf("data_out[%0d]", which), 32'(dout_of(which)), 32'(want));
    if (nbits != 0) begin
      // MISO streams the previous word MSB first, then zeros.
      if (nbits <= w) miso_exp = 32'(prev) >> (w - nbits);
      else            miso_exp = 32'(prev) << (nbits - w);
      chk($sformatf("miso_echo[%0d]", which), cap, miso_exp);
    end
    model_data[which] = exp_data;
    wait_cyc(4);
  endtask

  // Watches several refresh periods: one-hot enable, correct pattern for the
  // lit digit, DIV-cycle dwell, digits visited in ascending order.
  task automatic check_display(input int which, input logic [15:0] data);
    int bad, prev, run, switches, idx, nd;
    logic [3:0] e;
    logic full_run;
    nd = ndig_of[which];
    bad = 0; prev = -1; run = 0; switches = 0; full_run = 1'b0;
    for (int c = 0; c < 3 * nd * DIV + DIV; c++) begin
      @(negedge clk);
      e = en_h(which);
      idx = -1;
      for (int i = 0; i < nd; i++) if (e == 4'(1 << i)) idx = i;
      if (idx < 0) begin
        bad++;
      end else begin
        if (seg_h(which) != seg_of(data[4*idx +: 4])) bad++;
        if (idx == prev) begin
          run++;
        end else begin
          if (prev >= 0) begin
            switches++;
            if (full_run && run != DIV) bad++;
            if (idx != (prev + 1) % nd) bad++;
            full_run = 1'b1;
          end
          run = 1;
        end
        prev = idx;
      end
    end
    if (switches < nd) bad++;
    chk($sformatf("display[%0d]", which), 32'(bad), 32'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] cap;
    int pulses, which, nbits, w;
    logic [31:0] value;
    logic        ev;
    logic [15:0] ed;

    tbl[0] = '{0, 8,  32'hA5,   1'b1, 16'h00A5};
    tbl[1] = '{0, 8,  32'h3C,   1'b1, 16'h003C};
    tbl[2] = '{0, 8,  32'h00,   1'b1, 16'h0000};
    tbl[3] = '{0, 7,  32'h55,   1'b0, 16'h0000};
    tbl[4] = '{0, 9,  32'h1FF,  1'b0, 16'h0000};
    tbl[5] = '{0, 0,  32'h0,    1'b0, 16'h0000};
    tbl[6] = '{1, 16, 32'hBEEF, 1'b1, 16'hBEEF};
    tbl[7] = '{1, 15, 32'h1234, 1'b0, 16'hBEEF};
    tbl[8] = '{1, 17, 32'h1ABCD, 1'b0, 16'hBEEF};
    tbl[9] = '{0, 8,  32'hA5,   1'b1, 16'h00A5};

    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_data_out[%0d]", d), 32'(dout_of(d)), 32'h0);
      chk($sformatf("rst_valid[%0d]", d), 32'(valid_of(d)), 32'h0);
      chk($sformatf("rst_error[%0d]", d), 32'(err_of(d)), 32'h0);
      chk($sformatf("rst_miso[%0d]", d), 32'(miso_of(d)), 32'h0);
      chk($sformatf("rst_enable[%0d]", d), 32'(en_h(d)), 32'h1);
      chk($sformatf("rst_segments[%0d]", d), 32'(seg_h(d)), 32'(seg_of(4'h0)));
    end
    check_display(0, 16'h0000);
    check_display(1, 16'h0000);

    for (int t = 0; t < 10; t++) begin
      do_frame(tbl[t].which, tbl[t].nbits, tbl[t].value, tbl[t].exp_valid, tbl[t].exp_data);
      if (t == 0) check_display(0, 16'h00A5);
      if (t == 6) check_display(1, 16'hBEEF);
    end

    // Reset lands in the middle of a frame; nothing from it may surface.
    @(negedge clk);
    ss_n[0] = 1'b0;
    wait_cyc(6);
    shift_bits(0, 4, 32'hF, cap);
    @(negedge clk);
    rst = 1'b1;
    ss_n = 2'b11;
    wait_cyc(3);
    rst = 1'b0;
    model_data[0] = '0;
    model_data[1] = '0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      pulses += int'(valid_of(0)) + int'(err_of(0)) + int'(valid_of(1)) + int'(err_of(1));
    end
    chk("midframe_rst_pulses", 32'(pulses), 32'h0);
    chk("midframe_rst_data8", 32'(dout_of(0)), 32'h0);
    chk("midframe_rst_data16", 32'(dout_of(1)), 32'h0);
    do_frame(0, 8, 32'h81, 1'b1, 16'h0081);

    // Random traffic against the word-level model.
    for (int r = 0; r < 20; r++) begin
      which = int'($urandom_range(0, 1));
      w = w_of[which];
      if ($urandom_range(0, 2) == 0) nbits = int'($urandom_range(0, w + 2));
      else nbits = w;
      value = $urandom;
      ev = (nbits == w);
      ed = ev ? 16'(value & ((32'h1 << w) - 1)) : model_data[which];
      do_frame(which, nbits, value, ev, ed);
    end
    check_display(0, model_data[0]);
    check_display(1, model_data[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end
endmodule
